// File: rtl/mem_msg_pkg.sv
// Shared memory request/response message types.
// Used by every memory port responder and by its requesters.
package mem_msg_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  typedef struct packed {
    logic              mtype;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic              mtype;
    logic [DATA_W-1:0] data;
  } mem_resp_t;

endpackage

// File: rtl/mem_responder_resp_fifo.sv
// In-order response buffer: registered storage, combinational head.
// Extra pointer bit separates full from empty; a push into an empty buffer shows next cycle.
module resp_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] store [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage has no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr[IDX_W-1:0]] <= push_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign head  = store[rd_ptr[IDX_W-1:0]];

  always @(posedge clk) begin
    if (rst) begin
      assert (!(push && full)) else $error("resp_fifo: push while full");
      assert (!(pop && empty)) else $error("resp_fifo: pop while empty");
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: word array behind a val/rdy request port, fixed-latency
// in-order responses, and a credit-limited buffer that absorbs response back-pressure.
module mem_responder
  import mem_msg_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 256,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memreq_val,
  output logic              memreq_rdy,
  input  logic              memreq_type,
  input  logic [ADDR_W-1:0] memreq_addr,
  input  logic [DATA_W-1:0] memreq_wdata,
  output logic              memresp_val,
  input  logic              memresp_rdy,
  output logic              memresp_type,
  output logic [DATA_W-1:0] memresp_data
);

  localparam int unsigned AW     = $clog2(NUM_WORDS);
  localparam int unsigned CNT_W  = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned STAGES = LATENCY - 1;
  localparam int unsigned RESP_W = $bits(mem_resp_t);

  mem_req_t          req;
  mem_resp_t         fire_resp;
  mem_resp_t         push_data;
  mem_resp_t         head;
  logic              push;
  logic              full;
  logic              empty;
  logic              req_fire;
  logic              resp_fire;
  logic [AW-1:0]     idx;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  outstanding_next;
  logic              rdy_q;
  logic [DATA_W-1:0] words [NUM_WORDS];
  logic              unused_addr_bits;

  assign req = '{mtype: memreq_type, addr: memreq_addr, wdata: memreq_wdata};
  assign idx = req.addr[2 +: AW];
  assign unused_addr_bits = ^{req.addr[ADDR_W-1:2+AW], req.addr[1:0]};

  assign memreq_rdy = rdy_q;
  assign req_fire   = memreq_val && rdy_q;
  assign resp_fire  = memresp_val && memresp_rdy;

  // Credit counter; ready is a flop so a same-cycle pop never opens the request port.
  always_comb begin
    outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(resp_fire);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
      rdy_q       <= 1'b1;
    end else begin
      outstanding <= outstanding_next;
      rdy_q       <= (outstanding_next < CNT_W'(BUF_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire && req.mtype == MEMREQ_WRITE) words[idx] <= req.wdata;
  end

  assign fire_resp.mtype = req.mtype;
  assign fire_resp.data  = (req.mtype == MEMREQ_WRITE) ? '0 : words[idx];

  if (STAGES == 0) begin : g_direct
    assign push      = req_fire;
    assign push_data = fire_resp;
  end else begin : g_pipe
    logic [STAGES-1:0] val_q;
    mem_resp_t         resp_q [STAGES];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        val_q <= '0;
        for (int i = 0; i < STAGES; i++) resp_q[i] <= '0;
      end else begin
        val_q[0]  <= req_fire;
        resp_q[0] <= fire_resp;
        for (int i = 1; i < STAGES; i++) begin
          val_q[i]  <= val_q[i-1];
          resp_q[i] <= resp_q[i-1];
        end
      end
    end

    assign push      = val_q[STAGES-1];
    assign push_data = resp_q[STAGES-1];
  end

  resp_fifo #(
    .WIDTH (RESP_W),
    .DEPTH (BUF_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (resp_fire),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  assign memresp_val  = !empty;
  assign memresp_type = memresp_val ? head.mtype : 1'b0;
  assign memresp_data = memresp_val ? head.data : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus random traffic against a
// queue-of-due-responses reference model.
module tb_mem_responder;

  localparam int unsigned NUM_WORDS = 256;
  localparam int unsigned LATENCY   = 2;
  localparam int unsigned BUF_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        memreq_val;
  logic        memreq_rdy;
  logic        memreq_type;
  logic [31:0] memreq_addr;
  logic [31:0] memreq_wdata;
  logic        memresp_val;
  logic        memresp_rdy;
  logic        memresp_type;
  logic [31:0] memresp_data;

  mem_responder #(
    .NUM_WORDS (NUM_WORDS),
    .LATENCY   (LATENCY),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .memreq_val   (memreq_val),
    .memreq_rdy   (memreq_rdy),
    .memreq_type  (memreq_type),
    .memreq_addr  (memreq_addr),
    .memreq_wdata (memreq_wdata),
    .memresp_val  (memresp_val),
    .memresp_rdy  (memresp_rdy),
    .memresp_type (memresp_type),
    .memresp_data (memresp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        t;
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model_mem [NUM_WORDS];
  int          cyc;
  int          total;
  int          bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive, check outputs mid-cycle against the model, then advance the model.
  task automatic do_cycle(input logic v, input logic t, input logic [31:0] a,
                          input logic [31:0] wd, input logic rr);
    logic exp_rdy;
    logic exp_val;
    int   w;
    memreq_val   = v;
    memreq_type  = t;
    memreq_addr  = a;
    memreq_wdata = wd;
    memresp_rdy  = rr;
    @(negedge clk);
    exp_rdy = (q.size() < BUF_DEPTH);
    exp_val = (q.size() > 0) && (q[0].due <= cyc);
    check("memreq_rdy", 32'(memreq_rdy), 32'(exp_rdy));
    check("memresp_val", 32'(memresp_val), 32'(exp_val));
    if (exp_val) begin
      check("memresp_type", 32'(memresp_type), 32'(q[0].t));
      check("memresp_data", memresp_data, q[0].d);
    end else begin
      check("idle_type", 32'(memresp_type), 32'd0);
      check("idle_data", memresp_data, 32'd0);
    end
    if (exp_val && rr) void'(q.pop_front());
    if (v && exp_rdy) begin
      w = int'((a / 4) % NUM_WORDS);
      if (t) begin
        model_mem[w] = wd;
        q.push_back('{t: 1'b1, d: 32'd0, due: cyc + LATENCY});
      end else begin
        q.push_back('{t: 1'b0, d: model_mem[w], due: cyc + LATENCY});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 32'd0, 32'd0, rr);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst          = 1'b0;
    memreq_val   = 1'b0;
    memreq_type  = 1'b0;
    memreq_addr  = '0;
    memreq_wdata = '0;
    memresp_rdy  = 1'b0;

    #2;
    check("reset_val", 32'(memresp_val), 32'd0);
    check("reset_type", 32'(memresp_type), 32'd0);
    check("reset_data", memresp_data, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1, 1'b1);

    // Fill every word so later random reads have known data.
    for (int i = 0; i < NUM_WORDS; i++)
      do_cycle(1'b1, 1'b1, 32'(i * 4), $urandom, 1'b1);
    idle(4, 1'b1);

    // Write then read the same word on consecutive cycles.
    do_cycle(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
    do_cycle(1'b1, 1'b0, 32'h10, 32'd0, 1'b1);
    idle(4, 1'b1);

    // Back-to-back reads of 1,2,3,4.
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b1, 32'(i * 4), 32'(i + 1), 1'b1);
    idle(4, 1'b1);
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 32'(i * 4), 32'd0, 1'b1);
    idle(4, 1'b1);

    // Back-pressure: six reads offered, only four accepted, then drain.
    for (int i = 0; i < 6; i++) do_cycle(1'b1, 1'b0, 32'(i * 4), 32'd0, 1'b0);
    idle(3, 1'b0);
    idle(8, 1'b1);

    // Credit limit with pop and new request interleaved back to back.
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 32'(i * 4), 32'd0, 1'b0);
    idle(2, 1'b0);
    for (int i = 0; i < 10; i++) do_cycle(1'b1, 1'b0, 32'(8 + i * 4), 32'd0, 1'b1);
    idle(6, 1'b1);

    // Address wrap and ignored low bits.
    do_cycle(1'b1, 1'b1, 32'h400, 32'h55, 1'b1);
    do_cycle(1'b1, 1'b0, 32'h0, 32'd0, 1'b1);
    do_cycle(1'b1, 1'b1, 32'h10, 32'h11, 1'b1);
    do_cycle(1'b1, 1'b0, 32'h13, 32'd0, 1'b1);
    do_cycle(1'b1, 1'b0, 32'hFFFF_F010, 32'd0, 1'b1);
    idle(4, 1'b1);

    // Reset with three responses buffered and one still in the pipeline.
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 32'(i * 4), 32'd0, 1'b0);
    memreq_val = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check("async_reset_val", 32'(memresp_val), 32'd0);
    check("async_reset_data", memresp_data, 32'd0);
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc += 2;
    idle(5, 1'b1);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 400; i++)
      do_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom, $urandom,
               1'($urandom_range(0, 9) < 7));
    idle(10, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
